// File: rtl/pipeline_prog_loader.sv
// Host-driven program loader: streams I-MEM/D-MEM images from a word interface
// and gates the pipeline via cpu_hold, answering every command with one response word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a command header
// S_IMEM_WR | accepting I-MEM payload words, one write per word
// S_DMEM_LO | accepting the low half of a 64-bit D-MEM entry
// S_DMEM_HI | accepting the high half, then writing the entry
// S_DRAIN   | discarding payload of a load issued while the pipeline runs
// S_RESP    | presenting the response word until the host takes it
module pipeline_prog_loader #(
   parameter int IMEM_AW = 9,
   parameter int DMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic [31:0]        host_data,
   input  logic               host_last,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [31:0]        resp_data,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [63:0]        dmem_wdata,
   output logic               cpu_hold,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IMEM_WR,
      S_DMEM_LO,
      S_DMEM_HI,
      S_DRAIN,
      S_RESP
   } state_t;

   localparam logic [9:0] IMASK = 10'((32'd1 << IMEM_AW) - 32'd1);
   localparam logic [9:0] DMASK = 10'((32'd1 << DMEM_AW) - 32'd1);

   state_t      state;
   state_t      state_nxt;
   logic        started;
   logic [1:0]  op_q;
   logic        err_q;
   logic [10:0] rem_q;
   logic [9:0]  addr_q;
   logic [9:0]  wr_cnt_q;
   logic [31:0] lo_q;

   logic [1:0]  hdr_op;
   logic [9:0]  hdr_cnt;
   logic [9:0]  hdr_addr;
   logic        accept;
   logic        final_word;
   logic        end_err;
   logic [9:0]  addr_inc;

   assign hdr_op   = host_data[31:30];
   assign hdr_cnt  = host_data[25:16];
   assign hdr_addr = host_data[9:0];

   // started keeps host_ready low until the first edge after reset release
   assign host_ready = started && (state != S_RESP);
   assign accept     = host_valid && host_ready;
   assign resp_valid = (state == S_RESP);
   assign busy       = (state != S_IDLE);
   assign resp_data  = {op_q, err_q, 3'b000, wr_cnt_q, 6'b000000, addr_q};

   assign final_word = (rem_q == 11'd1);
   assign end_err    = final_word ? ~host_last : host_last;
   assign addr_inc   = (addr_q + 10'd1) & (op_q[0] ? DMASK : IMASK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (hdr_op[1] || (hdr_cnt == 10'd0) || host_last) begin
                  state_nxt = S_RESP;
               end else if (!cpu_hold) begin
                  state_nxt = S_DRAIN;
               end else if (hdr_op[0]) begin
                  state_nxt = S_DMEM_LO;
               end else begin
                  state_nxt = S_IMEM_WR;
               end
            end
         end
         S_IMEM_WR, S_DRAIN: begin
            if (accept && (final_word || host_last)) state_nxt = S_RESP;
         end
         S_DMEM_LO: begin
            if (accept) state_nxt = host_last ? S_RESP : S_DMEM_HI;
         end
         S_DMEM_HI: begin
            if (accept) state_nxt = (final_word || host_last) ? S_RESP : S_DMEM_LO;
         end
         S_RESP: begin
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started    <= 1'b0;
         cpu_hold   <= 1'b1;
         op_q       <= 2'b00;
         err_q      <= 1'b0;
         rem_q      <= '0;
         addr_q     <= '0;
         wr_cnt_q   <= '0;
         lo_q       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         started <= 1'b1;
         imem_we <= 1'b0;
         dmem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  op_q     <= hdr_op;
                  wr_cnt_q <= '0;
                  if (hdr_op[1]) begin
                     cpu_hold <= hdr_op[0];
                     addr_q   <= '0;
                     rem_q    <= '0;
                     err_q    <= ~host_last;
                  end else begin
                     addr_q <= hdr_addr & (hdr_op[0] ? DMASK : IMASK);
                     // a D-MEM drain has to swallow both halves of every entry
                     rem_q  <= (hdr_op[0] && !cpu_hold) ? {hdr_cnt, 1'b0} : {1'b0, hdr_cnt};
                     err_q  <= ~cpu_hold | ((hdr_cnt == 10'd0) ? ~host_last : host_last);
                  end
               end
               S_IMEM_WR: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr_q[IMEM_AW-1:0];
                  imem_wdata <= host_data;
                  addr_q     <= addr_inc;
                  wr_cnt_q   <= wr_cnt_q + 10'd1;
                  rem_q      <= rem_q - 11'd1;
                  err_q      <= err_q | end_err;
               end
               S_DMEM_LO: begin
                  lo_q  <= host_data;
                  err_q <= err_q | host_last;
               end
               S_DMEM_HI: begin
                  dmem_we    <= 1'b1;
                  dmem_addr  <= addr_q[DMEM_AW-1:0];
                  dmem_wdata <= {host_data, lo_q};
                  addr_q     <= addr_inc;
                  wr_cnt_q   <= wr_cnt_q + 10'd1;
                  rem_q      <= rem_q - 11'd1;
                  err_q      <= err_q | end_err;
               end
               S_DRAIN: begin
                  rem_q <= rem_q - 11'd1;
                  err_q <= err_q | end_err;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipeline_prog_loader.sv
// Randomized bench for pipeline_prog_loader: a command-level model predicts the
// memory writes, response word and cpu_hold for every command sent.
module tb_pipeline_prog_loader;
   localparam int IAW = 9;
   localparam int DAW = 8;

   logic           clk;
   logic           rst;
   logic           host_valid;
   logic           host_ready;
   logic [31:0]    host_data;
   logic           host_last;
   logic           resp_valid;
   logic           resp_ready;
   logic [31:0]    resp_data;
   logic           imem_we;
   logic [IAW-1:0] imem_addr;
   logic [31:0]    imem_wdata;
   logic           dmem_we;
   logic [DAW-1:0] dmem_addr;
   logic [63:0]    dmem_wdata;
   logic           cpu_hold;
   logic           busy;

   pipeline_prog_loader #(.IMEM_AW(IAW), .DMEM_AW(DAW)) dut (
      .clk        (clk),
      .rst        (rst),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_data  (host_data),
      .host_last  (host_last),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit hold_m = 1'b1;
   int stall_tot;

   int          got_ia[$];
   logic [31:0] got_id[$];
   int          got_da[$];
   logic [63:0] got_dd[$];
   int          exp_ia[$];
   logic [31:0] exp_id[$];
   int          exp_da[$];
   logic [63:0] exp_dd[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         got_ia.push_back(int'(imem_addr));
         got_id.push_back(imem_wdata);
      end
      if (dmem_we === 1'b1) begin
         got_da.push_back(int'(dmem_addr));
         got_dd.push_back(dmem_wdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, input bit last, input int max_gap);
      int g;
      int n;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      n = 0;
      repeat (g) begin
         host_valid = 1'b0;
         tick();
      end
      host_valid = 1'b1;
      host_data  = d;
      host_last  = last;
      while (host_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("host_ready_wait", host_ready, 1'b1);
      stall_tot += n;
      tick();
      host_valid = 1'b0;
      host_last  = 1'b0;
   endtask

   task automatic get_resp(input logic [31:0] exp, input int hold);
      int n;
      n = 0;
      host_valid = 1'b0;
      while (resp_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("resp_valid_wait", resp_valid, 1'b1);
      chk("resp_data", resp_data, exp);
      chk("busy_in_resp", busy, 1'b1);
      chk("ready_in_resp", host_ready, 1'b0);
      repeat (hold) begin
         tick();
         chk("resp_stable", resp_data, exp);
         chk("ready_in_resp_hold", host_ready, 1'b0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("resp_valid_after", resp_valid, 1'b0);
      chk("busy_after", busy, 1'b0);
   endtask

   task automatic check_writes();
      chk("imem_write_count", got_ia.size(), exp_ia.size());
      for (int i = 0; i < got_ia.size() && i < exp_ia.size(); i++) begin
         chk("imem_addr", got_ia[i], exp_ia[i]);
         chk("imem_data", got_id[i], exp_id[i]);
      end
      chk("dmem_write_count", got_da.size(), exp_da.size());
      for (int i = 0; i < got_da.size() && i < exp_da.size(); i++) begin
         chk("dmem_addr", got_da[i], exp_da[i]);
         chk("dmem_data", got_dd[i], exp_dd[i]);
      end
      got_ia.delete(); got_id.delete(); got_da.delete(); got_dd.delete();
      exp_ia.delete(); exp_id.delete(); exp_da.delete(); exp_dd.delete();
   endtask

   // early: payload index carrying a premature last (-1 for none)
   task automatic run_cmd(input logic [31:0] hdr, input bit hdr_last, input int early,
                          input bit final_last, input int max_gap, input int hold);
      logic [1:0]  op;
      int          cnt;
      int          modv;
      int          start;
      int          n;
      int          processed;
      int          written;
      bit          err;
      bit          early_term;
      logic [31:0] resp;
      logic [31:0] d;
      logic [31:0] w[$];
      op = hdr[31:30];
      cnt = int'(hdr[25:16]);
      stall_tot = 0;
      send_word(hdr, hdr_last, max_gap);
      if (op[1]) begin
         err    = !hdr_last;
         hold_m = op[0];
         resp   = {op, err, 29'd0};
      end else begin
         modv    = op[0] ? (1 << DAW) : (1 << IAW);
         start   = int'(hdr[9:0]) % modv;
         written = 0;
         if (cnt == 0 || hdr_last) begin
            err = (cnt == 0) ? (!hdr_last || !hold_m) : 1'b1;
         end else begin
            n          = op[0] ? 2 * cnt : cnt;
            early_term = (early >= 0) && (early < n - 1);
            processed  = early_term ? early + 1 : n;
            for (int i = 0; i < processed; i++) begin
               d = $urandom;
               w.push_back(d);
               send_word(d, (i == processed - 1) ? (early_term ? 1'b1 : final_last) : 1'b0, max_gap);
            end
            if (!hold_m) begin
               err = 1'b1;
            end else begin
               err = early_term || !final_last;
               if (op == 2'b00) begin
                  written = processed;
                  for (int i = 0; i < written; i++) begin
                     exp_ia.push_back((start + i) % modv);
                     exp_id.push_back(w[i]);
                  end
               end else begin
                  written = processed / 2;
                  for (int j = 0; j < written; j++) begin
                     exp_da.push_back((start + j) % modv);
                     exp_dd.push_back({w[2*j+1], w[2*j]});
                  end
               end
            end
         end
         resp = {op, err, 3'b000, 10'(written), 6'd0, 10'((start + written) % modv)};
      end
      get_resp(resp, hold);
      check_writes();
      chk("cpu_hold", cpu_hold, hold_m);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hdr;
      logic [31:0] wv[4];
      int          r;
      int          cnt;
      logic [1:0]  op;
      bit          hl;
      rst        = 1'b0;
      host_valid = 1'b0;
      host_data  = '0;
      host_last  = 1'b0;
      resp_ready = 1'b0;
      tick();
      tick();
      chk("rst_host_ready", host_ready, 1'b0);
      chk("rst_cpu_hold", cpu_hold, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_imem_we", imem_we, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      rst = 1'b1;
      #1;
      chk("ready_before_edge", host_ready, 1'b0);
      tick();
      chk("ready_after_edge", host_ready, 1'b1);

      run_cmd(32'h0003_0010, 1'b0, -1, 1'b1, 0, 0);
      chk("throughput_stalls", stall_tot, 0);
      run_cmd(32'h4002_00FF, 1'b0, -1, 1'b1, 1, 0);
      run_cmd(32'h8000_0000, 1'b1, -1, 1'b1, 0, 0);
      run_cmd(32'h0002_0005, 1'b0, -1, 1'b1, 1, 0);
      run_cmd(32'h4002_0005, 1'b0, -1, 1'b1, 1, 0);
      run_cmd(32'hC000_0000, 1'b1, -1, 1'b1, 0, 0);
      run_cmd(32'h0004_0100, 1'b0, 1, 1'b1, 1, 0);
      run_cmd(32'h0001_0020, 1'b0, -1, 1'b1, 0, 0);
      run_cmd(32'h4001_0010, 1'b0, -1, 1'b0, 0, 0);
      run_cmd(32'h0000_0123, 1'b1, -1, 1'b1, 0, 0);
      run_cmd(32'h4003_0004, 1'b1, -1, 1'b1, 0, 0);
      run_cmd(32'h0002_01FF, 1'b0, -1, 1'b1, 0, 5);
      run_cmd(32'h4002_0010, 1'b0, 2, 1'b1, 0, 0);

      for (int k = 0; k < 40; k++) begin
         r   = int'($urandom_range(0, 9));
         op  = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
         cnt = int'($urandom_range(0, 5));
         hdr = {op, 4'b0000, 10'(cnt), 6'd0, 10'($urandom_range(0, 1023))};
         hl  = (cnt == 0 || op[1]) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         run_cmd(hdr, hl, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
                 $urandom_range(0, 5) != 0, 2, int'($urandom_range(0, 3)));
      end

      run_cmd(32'hC000_0000, 1'b1, -1, 1'b1, 0, 0);
      for (int i = 0; i < 4; i++) wv[i] = $urandom;
      send_word(32'h4003_0000, 1'b0, 0);
      for (int i = 0; i < 4; i++) send_word(wv[i], 1'b0, 0);
      exp_da.push_back(0);
      exp_dd.push_back({wv[1], wv[0]});
      rst = 1'b0;
      #1;
      chk("rst_mid_dmem_we", dmem_we, 1'b0);
      chk("rst_mid_cpu_hold", cpu_hold, 1'b1);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_host_ready", host_ready, 1'b0);
      tick();
      tick();
      chk("rst_hold_dmem_we", dmem_we, 1'b0);
      check_writes();
      hold_m = 1'b1;
      rst = 1'b1;
      tick();
      run_cmd(32'h0002_0000, 1'b0, -1, 1'b1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
